// File: rtl/spi_pkg.sv
// Shared types and constants for the SPRAM-to-SPI readout block.
package spi_pkg;

   localparam int WORD_W       = 16;
   localparam int SPRAM_ADDR_W = 14;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      WAIT   = 3'd2,
      LOAD   = 3'd3,
      SHIFT  = 3'd4,
      FINISH = 3'd5
   } state_t;

endpackage

// File: rtl/spram_spi_tx_if.sv
// Control, SPRAM read-port and SPI pins of spram_spi_tx, grouped as one bundle.
interface spram_spi_tx_if #(
   parameter int ADDR_W = spi_pkg::SPRAM_ADDR_W
);

   logic              start;
   logic [ADDR_W-1:0] word_count;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [15:0]       mem_rdata;
   logic              sck;
   logic              sdo;
   logic              cs_n;
   logic              busy;
   logic              done;

   modport master (
      input  start, word_count, mem_rdata,
      output mem_addr, mem_rd, sck, sdo, cs_n, busy, done
   );

   modport slave (
      output start, word_count, mem_rdata,
      input  mem_addr, mem_rd, sck, sdo, cs_n, busy, done
   );

endinterface

// File: rtl/sck_gen.sv
// Mode-0 SPI clock generator: CLK_DIV cycles low, CLK_DIV cycles high while enabled.
module sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic nreset,
   input  logic en,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt;
   logic       phase_end;

   // Strobes flag the last cycle of a phase, i.e. sck changes on the next edge.
   assign phase_end = en && (cnt == DIV_LAST);
   assign rise      = phase_end && !sck;
   assign fall      = phase_end && sck;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (cnt == DIV_LAST) begin
         cnt <= '0;
         sck <= ~sck;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spram_spi_tx.sv
// SPRAM-to-SPI readout: fetches word_count 16-bit words from an external
// SPRAM read port and shifts them out MSB first on a mode-0 SPI link.
module spram_spi_tx
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int ADDR_W  = SPRAM_ADDR_W
) (
   input  logic           clk,
   input  logic           nreset,
   spram_spi_tx_if.master bus
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [4:0] BITS     = 5'(WORD_W);

   state_t            state, state_nx;
   logic [1:0]        rst_sync;
   logic              ready;
   logic [ADDR_W-1:0] addr, last_addr;
   logic [WORD_W-1:0] shreg;
   logic [4:0]        bit_cnt;
   logic [7:0]        fin_cnt;
   logic              sdo_q, done_q;
   logic              sck_en, sck_rise, sck_fall;
   logic              accept, zero_req, word_end, fin_end;

   // Reset release is re-timed so no start is acted on around the release edge.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign ready = rst_sync[1];

   assign accept   = (state == IDLE) && ready && bus.start && (bus.word_count != '0);
   assign zero_req = (state == IDLE) && ready && bus.start && (bus.word_count == '0);
   assign word_end = sck_fall && (bit_cnt == BITS);
   assign fin_end  = (state == FINISH) && (fin_cnt == DIV_LAST);

   sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk    (clk),
      .nreset (nreset),
      .en     (sck_en),
      .sck    (bus.sck),
      .rise   (sck_rise),
      .fall   (sck_fall)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx   = state;
      sck_en     = 1'b0;
      bus.mem_rd = 1'b0;
      bus.cs_n   = 1'b0;
      bus.busy   = 1'b1;
      unique case (state)
         IDLE: begin
            bus.cs_n = 1'b1;
            bus.busy = 1'b0;
            if (accept) state_nx = FETCH;
         end
         FETCH: begin
            bus.mem_rd = 1'b1;
            state_nx   = WAIT;
         end
         WAIT:  state_nx = LOAD;
         LOAD:  state_nx = SHIFT;
         SHIFT: begin
            sck_en = 1'b1;
            if (word_end) state_nx = (addr == last_addr) ? FINISH : FETCH;
         end
         FINISH: if (fin_end) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the shift register is plain flops, not a RAM, so it is cleared by reset like the rest.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         addr      <= '0;
         last_addr <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
         fin_cnt   <= '0;
         sdo_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= zero_req || fin_end;
         case (state)
            IDLE: if (accept) begin
               addr      <= '0;
               last_addr <= bus.word_count - 1'b1;
            end
            LOAD: begin
               shreg   <= bus.mem_rdata;
               sdo_q   <= bus.mem_rdata[WORD_W-1];
               bit_cnt <= '0;
            end
            SHIFT: begin
               fin_cnt <= '0;
               if (sck_rise) bit_cnt <= bit_cnt + 5'd1;
               // sdo moves only on a falling sck, giving a full low phase of setup.
               if (word_end) begin
                  if (addr != last_addr) addr <= addr + 1'b1;
               end else if (sck_fall) begin
                  shreg <= {shreg[WORD_W-2:0], 1'b0};
                  sdo_q <= shreg[WORD_W-2];
               end
            end
            FINISH:  fin_cnt <= fin_cnt + 8'd1;
            default: ;
         endcase
      end
   end

   assign bus.mem_addr = addr;
   assign bus.sdo      = sdo_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_spram_spi_tx.sv
// Bench for spram_spi_tx: two instances (CLK_DIV 2 and 1) with an SPRAM model,
// an SPI receiver monitor, and frame-level expectations computed from word counts.
module tb_spram_spi_tx;

   localparam int AW    = 14;
   localparam int D0    = 2;
   localparam int D1    = 1;
   localparam int LIMIT = 5000;

   logic clk    = 1'b0;
   logic nreset = 1'b1;
   always #5 clk = ~clk;

   spram_spi_tx_if #(.ADDR_W(AW)) bif0 ();
   spram_spi_tx_if #(.ADDR_W(AW)) bif1 ();

   spram_spi_tx #(.CLK_DIV(D0), .ADDR_W(AW)) u0 (.clk(clk), .nreset(nreset), .bus(bif0.master));
   spram_spi_tx #(.CLK_DIV(D1), .ADDR_W(AW)) u1 (.clk(clk), .nreset(nreset), .bus(bif1.master));

   logic          start_v [2];
   logic [AW-1:0] wc_v    [2];
   logic [15:0]   rdata_v [2];
   logic          sck_v [2], sdo_v [2], cs_v [2], busy_v [2], done_v [2], rd_v [2];
   logic [AW-1:0] addr_v [2];

   assign bif0.start      = start_v[0];
   assign bif1.start      = start_v[1];
   assign bif0.word_count = wc_v[0];
   assign bif1.word_count = wc_v[1];
   assign bif0.mem_rdata  = rdata_v[0];
   assign bif1.mem_rdata  = rdata_v[1];
   assign sck_v  = '{bif0.sck,      bif1.sck};
   assign sdo_v  = '{bif0.sdo,      bif1.sdo};
   assign cs_v   = '{bif0.cs_n,     bif1.cs_n};
   assign busy_v = '{bif0.busy,     bif1.busy};
   assign done_v = '{bif0.done,     bif1.done};
   assign rd_v   = '{bif0.mem_rd,   bif1.mem_rd};
   assign addr_v = '{bif0.mem_addr, bif1.mem_addr};

   function automatic int div_of(input int d);
      return (d == 0) ? D0 : D1;
   endfunction

   // SPRAM model: read data appears one clock after the strobe and holds.
   logic [15:0] mem [2][64];
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         if (rd_v[d]) rdata_v[d] <= mem[d][addr_v[d][5:0]];
   end

   // SPI receiver / protocol monitor, sampled on the falling clk edge.
   int          cyc;
   int          rise_tot [2], done_tot [2], rd_tot [2], busy_tot [2], cslo_tot [2], rx_tot [2];
   int          per_bad [2], hi_bad [2], stab_bad [2], edge_bad [2];
   int          rx_n [2], hi_len [2], stab [2], last_rise [2];
   bit          first [2];
   bit          prev_sck [2], prev_sdo [2];
   logic [15:0] rx_sr [2];
   logic [15:0] rx_mem [2][256];
   logic [AW-1:0] rd_log [2][256];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (done_v[d]) done_tot[d] <= done_tot[d] + 1;
         if (busy_v[d]) busy_tot[d] <= busy_tot[d] + 1;
         if (!cs_v[d])  cslo_tot[d] <= cslo_tot[d] + 1;
         if (rd_v[d]) begin
            rd_log[d][rd_tot[d] & 255] <= addr_v[d];
            rd_tot[d] <= rd_tot[d] + 1;
         end
         stab[d] <= (sdo_v[d] == prev_sdo[d]) ? stab[d] + 1 : 1;
         if (sck_v[d] && !prev_sck[d]) begin
            rise_tot[d] <= rise_tot[d] + 1;
            if (cs_v[d]) edge_bad[d] <= edge_bad[d] + 1;
            if (sdo_v[d] != prev_sdo[d] || stab[d] < div_of(d)) stab_bad[d] <= stab_bad[d] + 1;
            if (!first[d] && (cyc - last_rise[d]) != ((rx_n[d] == 0) ? 2 * div_of(d) + 3 : 2 * div_of(d)))
               per_bad[d] <= per_bad[d] + 1;
            first[d]     <= 1'b0;
            last_rise[d] <= cyc;
            rx_sr[d]     <= {rx_sr[d][14:0], sdo_v[d]};
            if (rx_n[d] == 15) begin
               rx_mem[d][rx_tot[d] & 255] <= {rx_sr[d][14:0], sdo_v[d]};
               rx_tot[d] <= rx_tot[d] + 1;
               rx_n[d]   <= 0;
            end else begin
               rx_n[d] <= rx_n[d] + 1;
            end
         end
         if (sck_v[d]) begin
            hi_len[d] <= hi_len[d] + 1;
         end else begin
            if (prev_sck[d] && hi_len[d] != div_of(d)) hi_bad[d] <= hi_bad[d] + 1;
            hi_len[d] <= 0;
         end
         if (cs_v[d]) begin
            first[d] <= 1'b1;
            rx_n[d]  <= 0;
         end
         prev_sck[d] <= sck_v[d];
         prev_sdo[d] <= sdo_v[d];
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete frame on instance d; optional extra start while the first word shifts.
   task automatic run_frame(input int d, input int wc, input bit mid_start);
      int b_rise, b_done, b_rd, b_busy, b_rx, b_per, b_hi, b_stab, b_edge, n;
      b_rise = rise_tot[d]; b_done = done_tot[d]; b_rd   = rd_tot[d];
      b_busy = busy_tot[d]; b_rx   = rx_tot[d];   b_per  = per_bad[d];
      b_hi   = hi_bad[d];   b_stab = stab_bad[d]; b_edge = edge_bad[d];
      @(posedge clk); #1;
      wc_v[d]    = AW'(wc);
      start_v[d] = 1'b1;
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      check("accept_busy", 32'(busy_v[d]), 32'd1);
      check("accept_cs_n", 32'(cs_v[d]), 32'd0);
      n = 0;
      while (done_v[d] !== 1'b1 && n < LIMIT) begin
         if (mid_start && n == 20 * div_of(d)) begin
            wc_v[d]    = AW'(wc + 3);
            start_v[d] = 1'b1;
         end else begin
            start_v[d] = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start_v[d] = 1'b0;
      check("done_timeout", 32'(n < LIMIT), 32'd1);
      check("done_busy_low", 32'(busy_v[d]), 32'd0);
      check("done_cs_n_high", 32'(cs_v[d]), 32'd1);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done_v[d]), 32'd0);
      @(negedge clk); #1;
      check("rise_edges", 32'(rise_tot[d] - b_rise), 32'(16 * wc));
      check("busy_cycles", 32'(busy_tot[d] - b_busy), 32'(wc * (3 + 32 * div_of(d)) + div_of(d)));
      check("done_pulses", 32'(done_tot[d] - b_done), 32'd1);
      check("rd_count", 32'(rd_tot[d] - b_rd), 32'(wc));
      for (int i = 0; i < wc; i++) begin
         check("rd_addr", 32'(rd_log[d][(b_rd + i) & 255]), 32'(i));
         check("rx_word", 32'(rx_mem[d][(b_rx + i) & 255]), 32'(mem[d][i]));
      end
      check("bit_period", 32'(per_bad[d] - b_per), 32'd0);
      check("sck_high_len", 32'(hi_bad[d] - b_hi), 32'd0);
      check("sdo_setup", 32'(stab_bad[d] - b_stab), 32'd0);
      check("edge_outside_cs", 32'(edge_bad[d] - b_edge), 32'd0);
   endtask

   initial begin
      int n, b_rise, b_done, b_rd, b_cs, wc;
      start_v = '{1'b0, 1'b0};
      wc_v    = '{'0, '0};
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 64; i++) mem[d][i] = 16'(i * 16'h0101);
      #2 nreset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_cs_n", 32'(cs_v[d]), 32'd1);
         check("rst_sck", 32'(sck_v[d]), 32'd0);
         check("rst_sdo", 32'(sdo_v[d]), 32'd0);
         check("rst_busy", 32'(busy_v[d]), 32'd0);
         check("rst_done", 32'(done_v[d]), 32'd0);
         check("rst_mem_rd", 32'(rd_v[d]), 32'd0);
         check("rst_mem_addr", 32'(addr_v[d]), 32'd0);
      end
      nreset = 1'b1;
      repeat (4) @(posedge clk);

      // single word
      mem[0][0] = 16'hA55A;
      run_frame(0, 1, 1'b0);

      // three words
      mem[0][0] = 16'h1234; mem[0][1] = 16'hABCD; mem[0][2] = 16'h0F0F;
      run_frame(0, 3, 1'b0);

      // zero length
      b_rd = rd_tot[0]; b_cs = cslo_tot[0]; b_rise = rise_tot[0]; b_done = done_tot[0];
      @(posedge clk); #1;
      wc_v[0] = '0; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      check("zero_done", 32'(done_v[0]), 32'd1);
      check("zero_busy", 32'(busy_v[0]), 32'd0);
      @(posedge clk); #1;
      check("zero_done_clear", 32'(done_v[0]), 32'd0);
      @(negedge clk); #1;
      check("zero_no_rd", 32'(rd_tot[0] - b_rd), 32'd0);
      check("zero_cs_idle", 32'(cslo_tot[0] - b_cs), 32'd0);
      check("zero_no_sck", 32'(rise_tot[0] - b_rise), 32'd0);
      check("zero_done_pulses", 32'(done_tot[0] - b_done), 32'd1);

      // start while busy
      mem[0][0] = 16'hC3E1; mem[0][1] = 16'h5A0F;
      run_frame(0, 2, 1'b1);

      // CLK_DIV=1, all ones then all zeros
      mem[1][0] = 16'hFFFF; mem[1][1] = 16'h0000;
      run_frame(1, 2, 1'b0);

      // randomized frames on both instances
      for (int k = 0; k < 6; k++) begin
         wc = int'($urandom_range(1, 4));
         for (int i = 0; i < wc; i++) mem[k % 2][i] = 16'($urandom);
         run_frame(k % 2, wc, k == 3);
      end

      // reset at bit 7 of the second word
      for (int i = 0; i < 3; i++) mem[0][i] = 16'($urandom);
      b_rise = rise_tot[0]; b_done = done_tot[0];
      @(posedge clk); #1;
      wc_v[0] = AW'(3); start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      n = 0;
      while ((rise_tot[0] - b_rise) < 23 && n < LIMIT) begin
         @(negedge clk); #1;
         n++;
      end
      check("rst_wait_timeout", 32'(n < LIMIT), 32'd1);
      #2 nreset = 1'b0;
      #1;
      check("midrst_cs_n", 32'(cs_v[0]), 32'd1);
      check("midrst_sck", 32'(sck_v[0]), 32'd0);
      check("midrst_busy", 32'(busy_v[0]), 32'd0);
      check("midrst_mem_addr", 32'(addr_v[0]), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("midrst_no_done", 32'(done_tot[0] - b_done), 32'd0);
      @(posedge clk); #1;
      nreset = 1'b1;
      wc_v[0] = AW'(2); start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      check("sync_start_ignored", 32'(busy_v[0]), 32'd0);
      repeat (3) @(posedge clk);
      run_frame(0, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
